// File: rtl/if_id_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_pipe_reg
//  Description : IF/ID interstage register with a 2-entry skid buffer.
//                Captures fetch PC, instruction and PC+4 and presents them to
//                decode through a valid/ready handshake. in_ready is decoded
//                from registered occupancy only, so there is no combinational
//                path from out_ready to in_ready. A synchronous flush discards
//                both entries and the incoming beat.
//                Optional feature macro: FLUSH_NOP_EN (flush leaves a single
//                NOP_INST beat in the main entry instead of emptying it).
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_pipe_reg #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] NOP_INST = XLEN'(32'h00000013)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_inst,
   input  logic [XLEN-1:0] in_pc4,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            flush,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_inst,
   output logic [XLEN-1:0] out_pc4,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [1:0]      occupancy
);

   localparam logic [1:0] C_OCC_EMPTY = 2'd0;
   localparam logic [1:0] C_OCC_ONE   = 2'd1;
   localparam logic [1:0] C_OCC_TWO   = 2'd2;

   logic [1:0]      occupancy_q, occupancy_d;
   logic [XLEN-1:0] main_pc_q,   main_pc_d;
   logic [XLEN-1:0] main_inst_q, main_inst_d;
   logic [XLEN-1:0] main_pc4_q,  main_pc4_d;
   logic [XLEN-1:0] skid_pc_q,   skid_pc_d;
   logic [XLEN-1:0] skid_inst_q, skid_inst_d;
   logic [XLEN-1:0] skid_pc4_q,  skid_pc4_d;

   logic w_push;
   logic w_pop;

   // Handshake decode: both ready and valid come straight from occupancy
   assign in_ready  = (occupancy_q != C_OCC_TWO);
   assign out_valid = (occupancy_q != C_OCC_EMPTY);
   assign w_push    = in_valid & in_ready & ~flush;
   assign w_pop     = out_valid & out_ready;

   assign out_pc    = main_pc_q;
   assign out_inst  = main_inst_q;
   assign out_pc4   = main_pc4_q;
   assign occupancy = occupancy_q;

   // Next-state: flush overrides everything, otherwise occupancy-driven moves
   always_comb begin
      occupancy_d = occupancy_q;
      main_pc_d   = main_pc_q;
      main_inst_d = main_inst_q;
      main_pc4_d  = main_pc4_q;
      skid_pc_d   = skid_pc_q;
      skid_inst_d = skid_inst_q;
      skid_pc4_d  = skid_pc4_q;

      if (flush) begin
         skid_pc_d   = '0;
         skid_inst_d = '0;
         skid_pc4_d  = '0;
         main_pc_d   = '0;
         main_pc4_d  = '0;
`ifdef FLUSH_NOP_EN
         // Wrong-path slot is replaced by a bubble instruction that drains normally
         occupancy_d = C_OCC_ONE;
         main_inst_d = NOP_INST;
`else
         occupancy_d = C_OCC_EMPTY;
         main_inst_d = '0;
`endif
      end else begin
         case (occupancy_q)
            C_OCC_EMPTY: begin
               if (w_push) begin
                  occupancy_d = C_OCC_ONE;
                  main_pc_d   = in_pc;
                  main_inst_d = in_inst;
                  main_pc4_d  = in_pc4;
               end
            end
            C_OCC_ONE: begin
               if (w_push && w_pop) begin
                  main_pc_d   = in_pc;
                  main_inst_d = in_inst;
                  main_pc4_d  = in_pc4;
               end else if (w_push) begin
                  // Decode stalled: park the new beat behind the visible one
                  occupancy_d = C_OCC_TWO;
                  skid_pc_d   = in_pc;
                  skid_inst_d = in_inst;
                  skid_pc4_d  = in_pc4;
               end else if (w_pop) begin
                  occupancy_d = C_OCC_EMPTY;
                  main_pc_d   = '0;
                  main_inst_d = '0;
                  main_pc4_d  = '0;
               end
            end
            C_OCC_TWO: begin
               if (w_pop) begin
                  occupancy_d = C_OCC_ONE;
                  main_pc_d   = skid_pc_q;
                  main_inst_d = skid_inst_q;
                  main_pc4_d  = skid_pc4_q;
                  skid_pc_d   = '0;
                  skid_inst_d = '0;
                  skid_pc4_d  = '0;
               end
            end
            default: begin
               // Unreachable encoding: recover to a clean empty buffer
               occupancy_d = C_OCC_EMPTY;
               main_pc_d   = '0;
               main_inst_d = '0;
               main_pc4_d  = '0;
               skid_pc_d   = '0;
               skid_inst_d = '0;
               skid_pc4_d  = '0;
            end
         endcase
      end
   end

   // State and data registers with asynchronous active-low clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         occupancy_q <= C_OCC_EMPTY;
         main_pc_q   <= '0;
         main_inst_q <= '0;
         main_pc4_q  <= '0;
         skid_pc_q   <= '0;
         skid_inst_q <= '0;
         skid_pc4_q  <= '0;
      end else begin
         occupancy_q <= occupancy_d;
         main_pc_q   <= main_pc_d;
         main_inst_q <= main_inst_d;
         main_pc4_q  <= main_pc4_d;
         skid_pc_q   <= skid_pc_d;
         skid_inst_q <= skid_inst_d;
         skid_pc4_q  <= skid_pc4_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_if_id_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_pipe_reg
//  Description : Self-checking bench for if_id_pipe_reg. Directed scenarios
//                plus a randomized run against a capacity-2 queue model.
//                Honours FLUSH_NOP_EN the same way the design does.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_pipe_reg;

   localparam int unsigned XLEN = 32;
   localparam logic [31:0] C_NOP = 32'h00000013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] pc4;
   } beat_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] in_pc, in_inst, in_pc4;
   logic        in_valid, flush, out_ready;
   logic        in_ready, out_valid;
   logic [31:0] out_pc, out_inst, out_pc4;
   logic [1:0]  occupancy;

   int checks = 0;
   int errors = 0;

   beat_t model_q[$];

   if_id_pipe_reg #(.XLEN(XLEN), .NOP_INST(C_NOP)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_pc     (in_pc),
      .in_inst   (in_inst),
      .in_pc4    (in_pc4),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_pc    (out_pc),
      .out_inst  (out_inst),
      .out_pc4   (out_pc4),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return (pc * 32'd7) ^ 32'hC0DE_0000;
   endfunction

   task automatic drive_beat(input logic v, input logic [31:0] pc);
      in_valid = v;
      in_pc    = pc;
      in_inst  = inst_of(pc);
      in_pc4   = pc + 32'd4;
   endtask

   // Reference: a FIFO of capacity 2 updated from the inputs seen at the edge
   task automatic model_step();
      bit    can_take;
      bit    take;
      bit    give;
      beat_t b;
      can_take = (model_q.size() < 2);
      take     = in_valid && can_take && !flush;
      give     = (model_q.size() > 0) && out_ready;
      if (flush) begin
         model_q.delete();
`ifdef FLUSH_NOP_EN
         b = '{pc: 32'd0, inst: C_NOP, pc4: 32'd0};
         model_q.push_back(b);
`endif
      end else begin
         if (give) void'(model_q.pop_front());
         if (take) begin
            b = '{pc: in_pc, inst: in_inst, pc4: in_pc4};
            model_q.push_back(b);
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_pc     = '0;
      in_inst   = '0;
      in_pc4    = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      model_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({out_valid, occupancy, in_ready} !== {1'b0, 2'd0, 1'b1} ||
          {out_pc, out_inst, out_pc4} !== 96'd0) begin
         errors++;
         $display("FAIL reset_state: valid=%0b occ=%0d rdy=%0b pc=%h inst=%h pc4=%h, want 0 0 1 and zero data",
                  out_valid, occupancy, in_ready, out_pc, out_inst, out_pc4);
      end
      // Fill two entries, then drop reset mid-cycle with no clock edge
      out_ready = 1'b0;
      drive_beat(1'b1, 32'h40); tick();
      drive_beat(1'b1, 32'h44); tick();
      drive_beat(1'b0, 32'h0);
      checks++;
      if (occupancy !== 2'd2) begin
         errors++;
         $display("FAIL reset_prefill: occ=%0d want 2", occupancy);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({out_valid, occupancy, in_ready} !== {1'b0, 2'd0, 1'b1} ||
          {out_pc, out_inst, out_pc4} !== 96'd0) begin
         errors++;
         $display("FAIL reset_async: valid=%0b occ=%0d rdy=%0b pc=%h, want 0 0 1 pc 0",
                  out_valid, occupancy, in_ready, out_pc);
      end
      model_q.delete();
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic test_streaming();
      logic [31:0] pcs [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
      apply_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive_beat(1'b1, pcs[i]);
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_pc !== pcs[i] || out_inst !== inst_of(pcs[i]) ||
             out_pc4 !== pcs[i] + 32'd4 || occupancy !== 2'd1) begin
            errors++;
            $display("FAIL stream_%0d: valid=%0b pc=%h occ=%0d, want 1 %h 1",
                     i, out_valid, out_pc, occupancy, pcs[i]);
         end
      end
      drive_beat(1'b0, 32'h0);
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_pc !== 32'd0 || occupancy !== 2'd0) begin
         errors++;
         $display("FAIL stream_drain: valid=%0b pc=%h occ=%0d, want 0 0 0", out_valid, out_pc, occupancy);
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      out_ready = 1'b0;
      drive_beat(1'b1, 32'h0); tick();
      drive_beat(1'b1, 32'h4); tick();
      drive_beat(1'b1, 32'h8); tick();
      checks++;
      if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_pc !== 32'h0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_full: occ=%0d rdy=%0b pc=%h valid=%0b, want 2 0 0 1",
                  occupancy, in_ready, out_pc, out_valid);
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_pc !== 32'h4 || out_inst !== inst_of(32'h4) || occupancy !== 2'd1) begin
         errors++;
         $display("FAIL bp_rel1: pc=%h occ=%0d, want 4 1", out_pc, occupancy);
      end
      tick();
      checks++;
      if (out_pc !== 32'h8 || out_pc4 !== 32'hC || occupancy !== 2'd1) begin
         errors++;
         $display("FAIL bp_rel2: pc=%h occ=%0d, want 8 1", out_pc, occupancy);
      end
      drive_beat(1'b0, 32'h0);
      tick();
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
         errors++;
         $display("FAIL bp_drain: valid=%0b occ=%0d, want 0 0", out_valid, occupancy);
      end
   endtask

   task automatic test_flush_full();
      apply_reset();
      out_ready = 1'b0;
      drive_beat(1'b1, 32'h0); tick();
      drive_beat(1'b1, 32'h4); tick();
      drive_beat(1'b1, 32'h10);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive_beat(1'b0, 32'h0);
      checks++;
`ifdef FLUSH_NOP_EN
      if (occupancy !== 2'd1 || out_valid !== 1'b1 || out_inst !== C_NOP ||
          out_pc !== 32'd0 || out_pc4 !== 32'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_full: occ=%0d valid=%0b inst=%h pc=%h rdy=%0b, want 1 1 %h 0 1",
                  occupancy, out_valid, out_inst, out_pc, in_ready, C_NOP);
      end
`else
      if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
          {out_pc, out_inst, out_pc4} !== 96'd0) begin
         errors++;
         $display("FAIL flush_full: occ=%0d valid=%0b rdy=%0b pc=%h, want 0 0 1 0",
                  occupancy, out_valid, in_ready, out_pc);
      end
`endif
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_pc === 32'h10) begin
         errors++;
         $display("FAIL flush_after: valid=%0b occ=%0d pc=%h, want 0 0 not 10",
                  out_valid, occupancy, out_pc);
      end
   endtask

   task automatic test_simultaneous();
      apply_reset();
      out_ready = 1'b0;
      drive_beat(1'b1, 32'h0); tick();
      out_ready = 1'b1;
      drive_beat(1'b1, 32'h20); tick();
      checks++;
      if (occupancy !== 2'd1 || out_pc !== 32'h20 || out_inst !== inst_of(32'h20) || out_pc4 !== 32'h24) begin
         errors++;
         $display("FAIL simul_push_pop: occ=%0d pc=%h, want 1 20", occupancy, out_pc);
      end
   endtask

   task automatic test_random();
      logic [31:0] next_pc;
      beat_t       exp_b;
      logic        exp_v;
      apply_reset();
      next_pc = 32'h1000;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 99) < 4);
         in_pc     = next_pc;
         in_inst   = $urandom;
         in_pc4    = next_pc + 32'd4;
         if (in_valid && model_q.size() < 2 && !flush) next_pc = next_pc + 32'd4;
         tick();
         exp_v = (model_q.size() != 0);
         exp_b = exp_v ? model_q[0] : beat_t'('0);
         checks++;
         if (occupancy !== 2'(model_q.size()) || out_valid !== exp_v ||
             in_ready !== (model_q.size() < 2) || occupancy > 2'd2) begin
            errors++;
            $display("FAIL rand_state@%0d: occ=%0d valid=%0b rdy=%0b, want occ %0d",
                     cyc, occupancy, out_valid, in_ready, model_q.size());
         end
         checks++;
         if ({out_pc, out_inst, out_pc4} !== exp_b) begin
            errors++;
            $display("FAIL rand_data@%0d: pc=%h inst=%h pc4=%h, want pc=%h inst=%h pc4=%h",
                     cyc, out_pc, out_inst, out_pc4, exp_b.pc, exp_b.inst, exp_b.pc4);
         end
      end
      flush    = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush_full();
      test_simultaneous();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
